// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, pcsource codes,
// instruction field positions and the PC-arithmetic helpers used by next_pc_calc.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Same encoding the control unit drives on pcsource.
  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_BR  = 2'b01,
    PCS_JMP = 2'b10,
    PCS_ILL = 2'b11
  } pcs_e;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int IMM16_MSB  = 15;
  localparam int IMM16_LSB  = 0;
  localparam int ADDR26_MSB = 25;
  localparam int ADDR26_LSB = 0;

  // Sign-extended 16-bit immediate, scaled to a word offset.
  function automatic logic [31:0] branch_offset(input logic [31:0] inst);
    return {{14{inst[IMM16_MSB]}}, inst[IMM16_MSB:IMM16_LSB], 2'b00};
  endfunction

  // Region-relative jump: keep the top nibble of pc+4, replace the rest.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] inst);
    return (pc_plus4 & 32'hF000_0000) | {4'b0000, inst[ADDR26_MSB:ADDR26_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump, or hold on illegal.
// All arithmetic is modulo 2^32.
module next_pc_calc
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [1:0]  pcsource,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic        unused_op;

  assign pc_plus4  = pc + 32'd4;
  // The opcode field plays no part in next-PC selection.
  assign unused_op = ^inst[OP_MSB:OP_LSB];

  always_comb begin
    // NOTE: assign a default before the case so every path drives next_pc (no latch).
    next_pc = pc_plus4;
    case (pcs_e'(pcsource))
      PCS_SEQ: next_pc = pc_plus4;
      PCS_BR:  next_pc = pc_plus4 + branch_offset(inst);
      PCS_JMP: next_pc = jump_target(pc_plus4, inst);
      PCS_ILL: next_pc = pc;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-fetch FSM (IDLE/FETCH/EXEC/HALT).
// Optional fetch-ack timeout enabled by defining FETCH_SEQ_TIMEOUT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic [1:0]  pcsource,
  input  logic        exe_stall,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fetch_err
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] next_pc;
  logic        tmo_hit;

  next_pc_calc u_next_pc_calc (
    .pc       (pc_q),
    .inst     (inst_q),
    .pcsource (pcsource),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // An ack wins over a timeout landing in the same cycle.
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ST_EXEC;
        end else if (tmo_hit) begin
          state_d = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (!exe_stall) begin
          if (pcs_e'(pcsource) == PCS_ILL) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and a synchronous reset
  // sampled on the clock edge; reset drops any ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef FETCH_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             fetch_err_q;

  // The counter idles at zero outside FETCH, so it is clear on every FETCH entry.
  assign tmo_hit = (state_q == ST_FETCH) && !imem_ack &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (state_q != ST_FETCH || imem_ack) tmo_cnt_q <= '0;
      else                                 tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      if (tmo_hit) fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  logic [31:0] unused_tmo;

  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == ST_EXEC);
  assign halted     = (state_q == ST_HALT);
  assign inst       = inst_q;
  assign pc         = pc_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and the instruction-fetch handshake with instruction memory.
- Presents each fetched word to the control unit for decode, then consumes the returned 2-bit pcsource to pick the next PC: sequential, branch, jump or halt.
- Sits between instruction memory and the decode/control stage of the multi-cycle CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT_CYCLES, 16, fetch-ack timeout limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  leave IDLE and begin fetching.
- imem_req  out  1  fetch request; high throughout FETCH.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  latched instruction driven to decode (op=inst[31:26], func=inst[5:0]).
- inst_valid  out  1  high while in EXEC.
- pcsource  in  2  next-PC select from control unit: 00 seq, 01 branch, 10 jump, 11 illegal.
- exe_stall  in  1  hold in EXEC (multi-cycle memory op in progress).
- pc  out  32  current PC.
- halted  out  1  high in HALT.
- fetch_err  out  1  timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high. All state updates on rising clk.
- Reset values: state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, halted=0, fetch_err=0.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: imem_req=0. start=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc, held stable until ack.
  - imem_ack=1 (including the first FETCH cycle) -> inst<=imem_rdata, go to EXEC.
  - Latency: ack in cycle N gives inst_valid=1 in cycle N+1.
- EXEC: inst_valid=1, inst held. pcsource is sampled only when exe_stall=0.
  - exe_stall=1 -> remain in EXEC, pc unchanged, pcsource ignored.
  - pcsource=00 -> pc<=pc+4, go to FETCH.
  - pcsource=01 -> pc<=pc+4+(sext(inst[15:0])<<2), go to FETCH.
  - pcsource=10 -> pc<=((pc+4) & 32'hF000_0000) | (inst[25:0]<<2), go to FETCH.
  - pcsource=11 -> pc unchanged, go to HALT.
- HALT: halted=1, imem_req=0. Sticky; only rst leaves HALT.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0. Negative branch offsets wrap the same way.
- imem_req and inst_valid decode combinationally from state. pc, inst and state are registered.
- Reset asserted in any state, including mid-FETCH: next cycle is IDLE, imem_req=0, and any pending ack is discarded.
- start is ignored outside IDLE. imem_ack is ignored outside FETCH.

Optional Feature:
- Macro FETCH_SEQ_TIMEOUT_EN.
- Defined: a counter clears on FETCH entry and increments each FETCH cycle without ack. When it reaches TIMEOUT_CYCLES, go to HALT with fetch_err=1; fetch_err stays 1 until rst.
- Undefined: no counter; FETCH waits indefinitely; fetch_err is constant 0.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, FETCH=2'd1, EXEC=2'd2, HALT=2'd3.
  - pcsource codes: PCS_SEQ, PCS_BR, PCS_JMP, PCS_ILL. These are the same codes the control unit drives.
  - Instruction field positions: OP_MSB/LSB, IMM16, ADDR26.
- One natural sub-module, next_pc_calc: combinational; inputs pc, inst, pcsource; output next_pc.

Test Plan:
- Reset then start, memory acks on the first FETCH cycle with 32'h0000_0001, pcsource=00 -> inst_valid the cycle after ack, pc 0->4, imem_addr=4 in the next FETCH.
- At pc=32'h0000_0010, inst[15:0]=16'hFFFE, pcsource=01 -> pc=32'h0000_000C. Same with imm 16'h0003 -> pc=32'h0000_0020.
- At pc=32'h4000_0100, inst[25:0]=26'h000_0040, pcsource=10 -> pc=32'h4000_0100 (upper nibble kept, low bits 0x100).
- Ack delayed 5 cycles -> imem_req and imem_addr stable for all 5 cycles. exe_stall=1 for 3 EXEC cycles with pcsource toggling -> pc unchanged until stall drops, then one update.
- pcsource=11 -> halted=1, imem_req=0 forever. rst asserted mid-FETCH and mid-HALT -> IDLE next cycle, pc=RESET_PC. pc=32'hFFFF_FFFC with seq -> pc=0.
- With FETCH_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> HALT and fetch_err=1 exactly 16 FETCH cycles after FETCH entry. Ack on cycle 15 -> normal EXEC, fetch_err=0.
